// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory among N_REQ requesters.
// One transaction is in flight at a time: accept, strobe, wait for mem_ready (with timeout), respond.
module mem_arbiter #(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [N_REQ*32-1:0]  req_addr,
    input  logic [N_REQ*32-1:0]  req_wdata,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_re,
    output logic                 mem_we,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    output logic                 busy
);

    localparam int unsigned     IW         = $clog2(N_REQ);
    localparam logic [IW-1:0]   LastIdx    = IW'(N_REQ - 1);
    localparam logic [7:0]      TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   win_q;
    logic            we_q;
    logic [7:0]      cnt_q;

    logic [IW-1:0]   win;
    logic            any_req;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin : pick
        logic [IW-1:0] idx;
        win     = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int off = 1; off <= int'(N_REQ); off++) begin
            idx = IW'((int'(rr_ptr_q) + off) % int'(N_REQ));
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

    // Gated by rst_n: no accept pulse may appear in a cycle where nothing is accepted.
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && rst_n && any_req) begin
            req_ready[win] = 1'b1;
        end
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= LastIdx;
            win_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        win_q     <= win;
                        rr_ptr_q  <= win;
                        we_q      <= req_we[win];
                        mem_addr  <= req_addr[32*win +: 32];
                        mem_wdata <= req_wdata[32*win +: 32];
                        mem_re    <= ~req_we[win];
                        mem_we    <= req_we[win];
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    mem_re  <= 1'b0;
                    mem_we  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (mem_ready) begin
                        rsp_valid <= N_REQ'(1) << win_q;
                        rsp_rdata <= we_q ? 32'd0 : mem_rdata;
                        rsp_err   <= 1'b0;
                        state_q   <= StResp;
                    end else if (cnt_q == TimeoutCnt) begin
                        rsp_valid <= N_REQ'(1) << win_q;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state_q   <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    rsp_valid <= '0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, write/read-back, fairness, timeout,
// reset mid-transaction and mixed contention, against a small memory model.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_we, req_ready, rsp_valid;
    logic [N*32-1:0]  req_addr, req_wdata;
    logic [31:0]      rsp_rdata, mem_addr, mem_wdata;
    logic             rsp_err, mem_re, mem_we, mem_ready, busy;
    logic [31:0]      mem_rdata   = '0;
    logic             model_ready = 1'b0;
    logic             mem_dead, inject;
    int unsigned      we_cnt = 0;
    int unsigned      w0;

    logic [31:0]      wmem [1024];
    logic [1023:0]    wr_valid = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    // Power-on memory contents: word 0x10 holds 0xDEADBEEF, others a tagged index.
    function automatic logic [31:0] init_word(input logic [9:0] idx);
        return (idx == 10'h10) ? 32'hDEAD_BEEF : (32'hA000_0000 | {22'd0, idx});
    endfunction

    // Memory answers the cycle after a strobe unless mem_dead is set.
    always @(posedge clk) begin
        model_ready <= 1'b0;
        if (!mem_dead && mem_re) begin
            model_ready <= 1'b1;
            mem_rdata   <= wr_valid[mem_addr[11:2]] ? wmem[mem_addr[11:2]]
                                                     : init_word(mem_addr[11:2]);
        end
        if (!mem_dead && mem_we) begin
            model_ready             <= 1'b1;
            wmem[mem_addr[11:2]]     <= mem_wdata;
            wr_valid[mem_addr[11:2]] <= 1'b1;
        end
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    assign mem_ready = model_ready | inject;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Full transaction from the accept cycle T to idle at T+4; req_valid is masked by keep at T+1.
    task automatic txn(input string tag, input int w, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic [N-1:0] keep);
        logic [N-1:0] oh;
        oh = N'(1) << w;
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'(oh));
        tick();
        req_valid = req_valid & keep;
        check({tag, ".re"}, 32'(mem_re), 32'(!we));
        check({tag, ".we"}, 32'(mem_we), 32'(we));
        check({tag, ".addr"}, mem_addr, addr);
        if (we) check({tag, ".wdata"}, mem_wdata, wdata);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        tick();
        check({tag, ".strobe_off"}, 32'({mem_re, mem_we}), 32'd0);
        tick();
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(oh));
        check({tag, ".rdata"}, rsp_rdata, rdata);
        check({tag, ".err"}, 32'(rsp_err), 32'd0);
        tick();
        check({tag, ".rsp_clear"}, 32'(rsp_valid), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_dead  = 1'b0;
        inject    = 1'b0;
        repeat (2) tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.strobes", 32'({mem_re, mem_we}), 32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single read by requester 1.
        req_valid[1]       = 1'b1;
        req_addr[32 +: 32] = 32'h40;
        txn("t1", 1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 3'b000);

        // Write then read back by requester 0.
        req_valid         = 3'b001;
        req_we            = 3'b001;
        req_addr[0 +: 32] = 32'h8;
        req_wdata[0 +: 32] = 32'h1234_5678;
        w0 = we_cnt;
        txn("t2w", 0, 1'b1, 32'h8, 32'h1234_5678, 32'h0, 3'b000);
        check("t2.we_pulses", we_cnt - w0, 32'd1);
        req_valid = 3'b001;
        req_we    = 3'b000;
        txn("t2r", 0, 1'b0, 32'h8, 32'h0, 32'h1234_5678, 3'b000);

        // Timeout: memory never answers.
        mem_dead           = 1'b1;
        req_valid          = 3'b010;
        req_addr[32 +: 32] = 32'h44;
        #1;
        check("t4.ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        check("t4.re", 32'(mem_re), 32'd1);
        repeat (16) tick();
        check("t4.still_busy", 32'(busy), 32'd1);
        check("t4.no_rsp_yet", 32'(rsp_valid), 32'd0);
        tick();
        check("t4.rsp_valid", 32'(rsp_valid), 32'b010);
        check("t4.err", 32'(rsp_err), 32'd1);
        check("t4.rdata", rsp_rdata, 32'd0);
        tick();
        check("t4.idle", 32'(busy), 32'd0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check("t4.late_ready_busy", 32'(busy), 32'd0);
        check("t4.late_ready_rsp", 32'(rsp_valid), 32'd0);
        tick();
        check("t4.late_ready_rsp2", 32'(rsp_valid), 32'd0);

        // Reset while waiting on a dead memory.
        req_valid          = 3'b100;
        req_addr[64 +: 32] = 32'h48;
        #1;
        check("t5.ready", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        tick();
        check("t5.in_wait", 32'(busy), 32'd1);
        rst_n     = 1'b0;
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) req_addr[32*i +: 32] = 32'(4 * (32'h20 + i));
        tick();
        check("t5.busy", 32'(busy), 32'd0);
        check("t5.rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5.strobes", 32'({mem_re, mem_we}), 32'd0);
        check("t5.mem_addr", mem_addr, 32'd0);
        check("t5.rsp_rdata", rsp_rdata, 32'd0);
        check("t5.rsp_err", 32'(rsp_err), 32'd0);
        check("t5.req_ready", 32'(req_ready), 32'd0);
        mem_dead = 1'b0;
        rst_n    = 1'b1;

        // Fairness: all three held, twelve back-to-back accepts, req0 first after reset.
        for (int k = 0; k < 12; k++) begin
            txn("fair", k % 3, 1'b0, 32'(4 * (32'h20 + k % 3)), 32'h0,
                init_word(10'(32'h20 + k % 3)), 3'b111);
        end
        req_valid = '0;

        // Mixed contention: 2 alone, then 0 and 2 together -> 0, then 2.
        req_valid = 3'b100;
        txn("t6a", 2, 1'b0, 32'h88, 32'h0, init_word(10'h22), 3'b000);
        req_valid = 3'b101;
        txn("t6b", 0, 1'b0, 32'h80, 32'h0, init_word(10'h20), 3'b100);
        txn("t6c", 2, 1'b0, 32'h88, 32'h0, init_word(10'h22), 3'b000);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
